// File: rtl/seg_pkg.sv
// Shared types and frame geometry for the segmentation pipeline
// (source memory, cluster engine and frame sink).
package seg_pkg;

    localparam int unsigned FRAME_DEPTH  = 66564;
    localparam int unsigned PIX_W        = 8;
    localparam int unsigned FRAME_ADDR_W = 18;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StCapture = 2'd1,
        StDrain   = 2'd2,
        StDone    = 2'd3
    } seg_state_e;

endpackage

// File: rtl/seg_sdp_ram.sv
// Simple dual-port frame buffer: one write port, one read port with
// registered read data (1-cycle latency). Contents are never reset.
module seg_sdp_ram #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 18,
    parameter int unsigned DEPTH  = 66564
) (
    input  logic              i_clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic              i_re,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    (* ram_style = "block" *) logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rdata;

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/seg_frame_sink.sv
// Frame sink: captures one labeled frame into the buffer in arrival order,
// then plays it back in address order over a valid/ready stream.
module seg_frame_sink
    import seg_pkg::*;
#(
    parameter int unsigned DATA_W = PIX_W,
    parameter int unsigned ADDR_W = FRAME_ADDR_W,
    parameter int unsigned DEPTH  = FRAME_DEPTH
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic              i_in_valid,
    output logic              o_in_ready,
    input  logic [DATA_W-1:0] i_in_data,
    input  logic              i_in_last,
    output logic              o_out_valid,
    input  logic              i_out_ready,
    output logic [DATA_W-1:0] o_out_data,
    output logic [ADDR_W-1:0] o_out_addr,
    output logic              o_out_last,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_frame_err,
    output logic [ADDR_W:0]   o_pix_count
);

    localparam logic [ADDR_W-1:0] AddrOne  = ADDR_W'(1);
    localparam logic [ADDR_W:0]   PixOne   = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W-1:0] AddrLast = ADDR_W'(DEPTH - 1);

    seg_state_e        r_state;
    logic              r_in_ready;
    logic              r_done;
    logic              r_frame_err;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [ADDR_W:0]   r_pix_count;

    logic [ADDR_W-1:0] r_rd_addr;
    logic              r_rd_done;
    logic              r_rd_vld;
    logic [ADDR_W-1:0] r_rd_tag;
    logic              r_skid_vld;
    logic [DATA_W-1:0] r_skid_data;
    logic [ADDR_W-1:0] r_skid_addr;
    logic              r_out_valid;
    logic [DATA_W-1:0] r_out_data;
    logic [ADDR_W-1:0] r_out_addr;
    logic              r_out_last;

    logic              w_in_fire;
    logic              w_wr_end;
    logic              w_out_fire;
    logic              w_out_load;
    logic [1:0]        w_occ;
    logic              w_rd_en;
    logic [ADDR_W-1:0] w_last_addr;
    logic [DATA_W-1:0] w_rdata;

    always_comb begin
        w_in_fire   = r_in_ready && i_in_valid;
        w_wr_end    = (r_wr_addr == AddrLast);
        w_out_fire  = r_out_valid && i_out_ready;
        w_out_load  = !r_out_valid || w_out_fire;
        w_last_addr = ADDR_W'(r_pix_count - PixOne);
        // Beats held after this cycle; output reg + skid give two slots, so
        // a new read is only issued when at most one slot will be taken.
        w_occ   = {1'b0, r_out_valid} + {1'b0, r_skid_vld} + {1'b0, r_rd_vld}
                - {1'b0, w_out_fire};
        w_rd_en = (r_state == StDrain) && !r_rd_done && (w_occ <= 2'd1);
    end

    seg_sdp_ram #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W),
        .DEPTH (DEPTH)
    ) u_ram (
        .i_clk  (i_clk),
        .i_we   (w_in_fire),
        .i_waddr(r_wr_addr),
        .i_wdata(i_in_data),
        .i_re   (w_rd_en),
        .i_raddr(r_rd_addr),
        .o_rdata(w_rdata)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= StIdle;
            r_in_ready  <= 1'b0;
            r_done      <= 1'b0;
            r_frame_err <= 1'b0;
            r_wr_addr   <= '0;
            r_pix_count <= '0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (i_start) begin
                        r_state     <= StCapture;
                        r_in_ready  <= 1'b1;
                        r_wr_addr   <= '0;
                        r_pix_count <= '0;
                        r_frame_err <= 1'b0;
                    end
                end
                StCapture: begin
                    if (w_in_fire) begin
                        r_wr_addr   <= r_wr_addr + AddrOne;
                        r_pix_count <= r_pix_count + PixOne;
                        if (w_wr_end || i_in_last) begin
                            r_state     <= StDrain;
                            r_in_ready  <= 1'b0;
                            r_frame_err <= !(w_wr_end && i_in_last);
                        end
                    end
                end
                StDrain: begin
                    if (w_out_fire && r_out_last) begin
                        r_state <= StDone;
                        r_done  <= 1'b1;
                    end
                end
                StDone: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_rd_addr   <= '0;
            r_rd_done   <= 1'b0;
            r_rd_vld    <= 1'b0;
            r_rd_tag    <= '0;
            r_skid_vld  <= 1'b0;
            r_skid_data <= '0;
            r_skid_addr <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_addr  <= '0;
            r_out_last  <= 1'b0;
        end else begin
            if (r_state != StDrain) begin
                r_rd_addr <= '0;
                r_rd_done <= 1'b0;
            end else if (w_rd_en) begin
                r_rd_addr <= r_rd_addr + AddrOne;
                if (r_rd_addr == w_last_addr) begin
                    r_rd_done <= 1'b1;
                end
            end

            r_rd_vld <= w_rd_en;
            if (w_rd_en) begin
                r_rd_tag <= r_rd_addr;
            end

            // Output register refills from the skid first to keep order.
            if (w_out_load) begin
                if (r_skid_vld) begin
                    r_out_valid <= 1'b1;
                    r_out_data  <= r_skid_data;
                    r_out_addr  <= r_skid_addr;
                    r_out_last  <= (r_skid_addr == w_last_addr);
                end else if (r_rd_vld) begin
                    r_out_valid <= 1'b1;
                    r_out_data  <= w_rdata;
                    r_out_addr  <= r_rd_tag;
                    r_out_last  <= (r_rd_tag == w_last_addr);
                end else begin
                    r_out_valid <= 1'b0;
                    r_out_last  <= 1'b0;
                end
            end

            if (r_rd_vld && !(w_out_load && !r_skid_vld)) begin
                r_skid_vld  <= 1'b1;
                r_skid_data <= w_rdata;
                r_skid_addr <= r_rd_tag;
            end else if (w_out_load && r_skid_vld) begin
                r_skid_vld <= 1'b0;
            end
        end
    end

    assign o_in_ready  = r_in_ready;
    assign o_out_valid = r_out_valid;
    assign o_out_data  = r_out_data;
    assign o_out_addr  = r_out_addr;
    assign o_out_last  = r_out_last;
    assign o_busy      = (r_state == StCapture) || (r_state == StDrain);
    assign o_done      = r_done;
    assign o_frame_err = r_frame_err;
    assign o_pix_count = r_pix_count;

endmodule
